// File: rtl/pipeline_controller_pkg.sv
// Shared encodings for the pipeline controller: memory FSM states,
// forward-select codes, the hard-wired zero register and the stall timeout.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ABORT = 2'b10
  } mem_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_M   = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  localparam logic [4:0] ZERO_REG          = 5'd0;
  localparam logic [7:0] STALL_TIMEOUT_MAX = 8'd255;

  // Nearest producing stage wins; register 0 is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] src,
    input logic       ex_wr,
    input logic [4:0] ex_rd,
    input logic       m_wr,
    input logic [4:0] m_rd,
    input logic       wb_wr,
    input logic [4:0] wb_rd
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (src != ZERO_REG) begin
      if (ex_wr && ex_rd == src)      sel = FWD_EX;
      else if (m_wr && m_rd == src)   sel = FWD_M;
      else if (wb_wr && wb_rd == src) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Pipeline-side bundle of the controller: stage hazard info and memory
// handshake in, stall/flush/forward controls out.
interface pipeline_controller_if;

  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_NeedRsByID;
  logic       ID_NeedRtByID;
  logic       ID_WantRsByEX;
  logic       ID_NeedRsByEX;
  logic       ID_WantRtByEX;
  logic       ID_NeedRtByEX;
  logic       EX_RegWrite;
  logic       EX_MemRead;
  logic [4:0] EX_RtRd;
  logic       M_RegWrite;
  logic       M_MemRead;
  logic       M_MemWrite;
  logic [4:0] M_RtRd;
  logic       WB_RegWrite;
  logic [4:0] WB_RtRd;
  logic       EX_ALUBusy;
  logic       InstMem_Ready;
  logic       DataMem_Ready;
  logic       Exc_Flush;

  logic       IF_Stall;
  logic       ID_Stall;
  logic       EX_Stall;
  logic       M_Stall;
  logic       IF_Flush;
  logic       ID_Flush;
  logic       EX_Flush;
  logic       M_Flush;
  logic       DataMem_Req;
  logic [1:0] ID_RsFwdSel;
  logic [1:0] ID_RtFwdSel;
  logic       Stall_Timeout;

  modport master (
    output ID_Rs, ID_Rt, ID_NeedRsByID, ID_NeedRtByID, ID_WantRsByEX,
           ID_NeedRsByEX, ID_WantRtByEX, ID_NeedRtByEX, EX_RegWrite,
           EX_MemRead, EX_RtRd, M_RegWrite, M_MemRead, M_MemWrite, M_RtRd,
           WB_RegWrite, WB_RtRd, EX_ALUBusy, InstMem_Ready, DataMem_Ready,
           Exc_Flush,
    input  IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush,
           EX_Flush, M_Flush, DataMem_Req, ID_RsFwdSel, ID_RtFwdSel,
           Stall_Timeout
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_NeedRsByID, ID_NeedRtByID, ID_WantRsByEX,
           ID_NeedRsByEX, ID_WantRtByEX, ID_NeedRtByEX, EX_RegWrite,
           EX_MemRead, EX_RtRd, M_RegWrite, M_MemRead, M_MemWrite, M_RtRd,
           WB_RegWrite, WB_RtRd, EX_ALUBusy, InstMem_Ready, DataMem_Ready,
           Exc_Flush,
    output IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush,
           EX_Flush, M_Flush, DataMem_Req, ID_RsFwdSel, ID_RtFwdSel,
           Stall_Timeout
  );

endinterface

// File: rtl/pipeline_controller_mem_access_fsm.sv
// Data-memory access sequencer for the M stage plus the saturating
// stall-length counter that raises the timeout flag.
module mem_access_fsm
  import pipeline_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic mem_ready,
  input  logic exc_flush,
  output logic mem_req,
  output logic m_stall,
  output logic flush,
  output logic stall_timeout
);

  mem_state_e state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic       req_int, busy_int, flush_int;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_int    = 1'b0;
    busy_int   = 1'b0;
    flush_int  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (exc_flush) begin
          flush_int = 1'b1;
        end else if (mem_read || mem_write) begin
          req_int = 1'b1;
          if (!mem_ready) begin
            busy_int   = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req_int = 1'b1;
        if (mem_ready) begin
          // An exception landing on the completing cycle flushes right away.
          flush_int  = exc_flush;
          state_next = ST_IDLE;
        end else begin
          busy_int = 1'b1;
          if (exc_flush) state_next = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // The bus cycle must finish before the pipeline can be flushed;
        // further exceptions here are absorbed.
        req_int = 1'b1;
        if (mem_ready) begin
          flush_int  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          busy_int = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next = '0;
    if (busy_int) begin
      count_next = (count_reg == STALL_TIMEOUT_MAX) ? count_reg : count_reg + 8'd1;
    end
  end

  // Reset level gates the outputs so they drop the instant reset asserts.
  assign mem_req       = reset & req_int;
  assign m_stall       = reset & busy_int;
  assign flush         = reset & flush_int;
  assign stall_timeout = reset & (count_reg == STALL_TIMEOUT_MAX);

endmodule

// File: rtl/pipeline_controller.sv
// Hazard detection, operand forwarding and the stall/flush chain for a
// five-stage pipeline; memory sequencing lives in mem_access_fsm.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  pipeline_controller_if.slave  bus
);

  logic [4:0] src [2];
  logic [1:0] need_id;
  logic [1:0] need_ex;
  logic [1:0] fwd_sel [2];
  logic [1:0] hazard_lu;
  logic [1:0] hazard_br;
  logic       m_stall, ex_stall, id_stall, if_stall;
  logic       flush_all;
  logic       unused_want;

  assign src[0]  = bus.ID_Rs;
  assign src[1]  = bus.ID_Rt;
  assign need_id = {bus.ID_NeedRtByID, bus.ID_NeedRsByID};
  assign need_ex = {bus.ID_NeedRtByEX, bus.ID_NeedRsByEX};

  // Want flags never stall; forwarding is selected regardless of them.
  assign unused_want = bus.ID_WantRsByEX ^ bus.ID_WantRtByEX;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign fwd_sel[gi] = fwd_select(src[gi],
                                      bus.EX_RegWrite, bus.EX_RtRd,
                                      bus.M_RegWrite,  bus.M_RtRd,
                                      bus.WB_RegWrite, bus.WB_RtRd);

      assign hazard_lu[gi] = bus.EX_MemRead && (bus.EX_RtRd != ZERO_REG) &&
                             (bus.EX_RtRd == src[gi]) &&
                             (need_id[gi] || need_ex[gi]);

      assign hazard_br[gi] = need_id[gi] &&
                             ((bus.EX_RegWrite && (bus.EX_RtRd != ZERO_REG) &&
                               (bus.EX_RtRd == src[gi])) ||
                              (bus.M_MemRead && (bus.M_RtRd != ZERO_REG) &&
                               (bus.M_RtRd == src[gi])));
    end
  endgenerate

  mem_access_fsm u_mem (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (bus.M_MemRead),
    .mem_write     (bus.M_MemWrite),
    .mem_ready     (bus.DataMem_Ready),
    .exc_flush     (bus.Exc_Flush),
    .mem_req       (bus.DataMem_Req),
    .m_stall       (m_stall),
    .flush         (flush_all),
    .stall_timeout (bus.Stall_Timeout)
  );

  assign ex_stall = m_stall  | (reset & bus.EX_ALUBusy);
  assign id_stall = ex_stall | (reset & ((|hazard_lu) | (|hazard_br)));
  assign if_stall = id_stall | (reset & ~bus.InstMem_Ready);

  assign bus.M_Stall     = m_stall;
  assign bus.EX_Stall    = ex_stall;
  assign bus.ID_Stall    = id_stall;
  assign bus.IF_Stall    = if_stall;
  assign bus.IF_Flush    = flush_all;
  assign bus.ID_Flush    = flush_all;
  assign bus.EX_Flush    = flush_all;
  assign bus.M_Flush     = flush_all;
  assign bus.ID_RsFwdSel = fwd_sel[0];
  assign bus.ID_RtFwdSel = fwd_sel[1];

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed-vector bench: the driver queues the expected response of each
// cycle, a negedge monitor pops it and compares against the live outputs.
module tb_pipeline_controller;

  logic clk;
  logic rst_n;

  pipeline_controller_if bus ();

  pipeline_controller dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vec = {stall IF,ID,EX,M, flush IF,ID,EX,M, req, rs_sel, rt_sel, timeout}
  typedef struct {
    string       name;
    logic [13:0] vec;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [13:0] act;
      e   = exp_q.pop_front();
      act = {bus.IF_Stall, bus.ID_Stall, bus.EX_Stall, bus.M_Stall,
             bus.IF_Flush, bus.ID_Flush, bus.EX_Flush, bus.M_Flush,
             bus.DataMem_Req, bus.ID_RsFwdSel, bus.ID_RtFwdSel,
             bus.Stall_Timeout};
      n_cmp++;
      if (act !== e.vec) begin
        n_err++;
        $display("FAIL %s: outputs got %b expected %b", e.name, act, e.vec);
      end else begin
        $display("pass %s: outputs %b", e.name, act);
      end
      if (e.cnt >= 0) begin
        n_cmp++;
        if (int'(dut.u_mem.count_reg) != e.cnt) begin
          n_err++;
          $display("FAIL %s_cnt: counter got %0d expected %0d",
                   e.name, dut.u_mem.count_reg, e.cnt);
        end
      end
    end
  end

  task automatic defaults();
    bus.ID_Rs = 5'd0;          bus.ID_Rt = 5'd0;
    bus.ID_NeedRsByID = 1'b0;  bus.ID_NeedRtByID = 1'b0;
    bus.ID_WantRsByEX = 1'b0;  bus.ID_NeedRsByEX = 1'b0;
    bus.ID_WantRtByEX = 1'b0;  bus.ID_NeedRtByEX = 1'b0;
    bus.EX_RegWrite = 1'b0;    bus.EX_MemRead = 1'b0;   bus.EX_RtRd = 5'd0;
    bus.M_RegWrite = 1'b0;     bus.M_MemRead = 1'b0;    bus.M_MemWrite = 1'b0;
    bus.M_RtRd = 5'd0;
    bus.WB_RegWrite = 1'b0;    bus.WB_RtRd = 5'd0;
    bus.EX_ALUBusy = 1'b0;     bus.InstMem_Ready = 1'b1;
    bus.DataMem_Ready = 1'b1;  bus.Exc_Flush = 1'b0;
  endtask

  // Inputs are already set; queue the expectation and advance one cycle.
  task automatic apply(input string nm, input logic [3:0] st, input logic [3:0] fl,
                       input logic rq, input logic [1:0] rs, input logic [1:0] rt,
                       input logic to, input int cnt);
    exp_t e;
    e.name = nm;
    e.vec  = {st, fl, rq, rs, rt, to};
    e.cnt  = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    defaults();
    @(posedge clk);
    #1;

    // Held in reset with everything provoking: only forwarding may move.
    bus.ID_Rs = 5'd5; bus.EX_RegWrite = 1'b1; bus.EX_RtRd = 5'd5;
    bus.InstMem_Ready = 1'b0; bus.M_MemWrite = 1'b1; bus.DataMem_Ready = 1'b0;
    bus.Exc_Flush = 1'b1; bus.EX_ALUBusy = 1'b1;
    apply("reset_hold", 4'b0000, 4'b0000, 1'b0, 2'b01, 2'b00, 1'b0, 0);

    rst_n = 1'b1;
    defaults();
    apply("idle", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 0);

    defaults();
    bus.ID_Rs = 5'd3; bus.ID_Rt = 5'd4;
    bus.M_RegWrite = 1'b1; bus.M_RtRd = 5'd3;
    bus.WB_RegWrite = 1'b1; bus.WB_RtRd = 5'd4;
    apply("fwd_m_wb", 4'b0000, 4'b0000, 1'b0, 2'b10, 2'b11, 1'b0, -1);

    defaults();
    bus.ID_Rs = 5'd7; bus.ID_Rt = 5'd7; bus.ID_WantRsByEX = 1'b1;
    bus.EX_RegWrite = 1'b1; bus.EX_RtRd = 5'd7;
    bus.M_RegWrite = 1'b1; bus.M_RtRd = 5'd7;
    bus.WB_RegWrite = 1'b1; bus.WB_RtRd = 5'd7;
    apply("fwd_priority", 4'b0000, 4'b0000, 1'b0, 2'b01, 2'b01, 1'b0, -1);

    // lw $5 in EX, add using $5 in EX stage of its own
    defaults();
    bus.ID_Rs = 5'd5; bus.ID_NeedRsByEX = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_RtRd = 5'd5;
    apply("load_use", 4'b1100, 4'b0000, 1'b0, 2'b01, 2'b00, 1'b0, -1);

    defaults();
    bus.ID_Rs = 5'd5; bus.ID_NeedRsByEX = 1'b1;
    bus.M_MemRead = 1'b1; bus.M_RegWrite = 1'b1; bus.M_RtRd = 5'd5;
    apply("load_use_next", 4'b0000, 4'b0000, 1'b1, 2'b10, 2'b00, 1'b0, 0);

    defaults();
    bus.ID_Rt = 5'd6; bus.ID_WantRtByEX = 1'b1;
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_RtRd = 5'd6;
    apply("want_only_load", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b01, 1'b0, -1);

    defaults();
    bus.ID_Rt = 5'd9; bus.ID_NeedRtByID = 1'b1;
    bus.EX_RegWrite = 1'b1; bus.EX_RtRd = 5'd9;
    apply("branch_ex", 4'b1100, 4'b0000, 1'b0, 2'b00, 2'b01, 1'b0, -1);

    defaults();
    bus.ID_Rs = 5'd10; bus.ID_NeedRsByID = 1'b1;
    bus.M_MemRead = 1'b1; bus.M_RegWrite = 1'b1; bus.M_RtRd = 5'd10;
    apply("branch_m_load", 4'b1100, 4'b0000, 1'b1, 2'b10, 2'b00, 1'b0, -1);

    defaults();
    bus.ID_Rs = 5'd10; bus.ID_NeedRsByID = 1'b1;
    bus.M_RegWrite = 1'b1; bus.M_RtRd = 5'd10;
    apply("branch_m_alu", 4'b0000, 4'b0000, 1'b0, 2'b10, 2'b00, 1'b0, -1);

    defaults();
    bus.ID_NeedRsByID = 1'b1; bus.ID_NeedRsByEX = 1'b1;
    bus.EX_RegWrite = 1'b1; bus.EX_MemRead = 1'b1;
    apply("zero_reg", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, -1);

    defaults();
    bus.InstMem_Ready = 1'b0;
    apply("imem_wait", 4'b1000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, -1);

    defaults();
    bus.EX_ALUBusy = 1'b1;
    apply("alu_busy", 4'b1110, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 0);

    // sw waiting three cycles on data memory
    defaults();
    bus.M_MemWrite = 1'b1; bus.DataMem_Ready = 1'b0;
    apply("sw_wait1", 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 0);
    apply("sw_wait2", 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1);
    apply("sw_wait3", 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 2);
    bus.DataMem_Ready = 1'b1;
    apply("sw_ready", 4'b0000, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 3);
    defaults();
    apply("sw_done", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 0);

    // exception while a load waits: deferred flush on Ready
    defaults();
    bus.M_MemRead = 1'b1; bus.DataMem_Ready = 1'b0;
    apply("abort_req", 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 0);
    bus.Exc_Flush = 1'b1;
    apply("abort_exc", 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 1);
    apply("abort_absorb", 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00, 1'b0, 2);
    bus.Exc_Flush = 1'b0; bus.DataMem_Ready = 1'b1;
    apply("abort_ready", 4'b0000, 4'b1111, 1'b1, 2'b00, 2'b00, 1'b0, 3);
    defaults();
    apply("abort_done", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 0);

    // exception in IDLE: flush wins, request suppressed, stall chain intact
    defaults();
    bus.M_MemRead = 1'b1; bus.EX_ALUBusy = 1'b1; bus.Exc_Flush = 1'b1;
    apply("idle_flush", 4'b1110, 4'b1111, 1'b0, 2'b00, 2'b00, 1'b0, -1);
    defaults();
    apply("idle_flush_end", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, -1);

    // 300-cycle memory hang
    defaults();
    bus.M_MemRead = 1'b1; bus.DataMem_Ready = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      apply($sformatf("hang_%0d", k), 4'b1111, 4'b0000, 1'b1, 2'b00, 2'b00,
            (k - 1) >= 255, ((k - 1) > 255) ? 255 : (k - 1));
    end
    rst_n = 1'b0;
    apply("hang_reset", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    rst_n = 1'b1;
    bus.M_MemRead = 1'b0;
    apply("post_reset_idle", 4'b0000, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
